// File: rtl/audio_i2s_tx_if.sv
// Stereo PCM sample stream feeding the I2S transmitter.
// One transfer carries a left/right pair; it moves when s_valid && s_ready.
interface audio_i2s_tx_if #(
  parameter int SAMPLE_WIDTH = 16
) ();
  logic                    s_valid;
  logic                    s_ready;
  logic [SAMPLE_WIDTH-1:0] s_left;
  logic [SAMPLE_WIDTH-1:0] s_right;

  // Sound generator side: offers pairs.
  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready
  );

  // Transmitter side: accepts pairs into its FIFO.
  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready
  );
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the Pocket audio_if DAC path.
// Stereo pairs enter a small FIFO over a valid/ready stream. One pair is
// popped at every frame boundary and shifted out MSB first, one slot after
// each lrck edge. An empty FIFO at a boundary is an underflow: the frame is
// silence, or a repeat of the last popped pair when UNDERFLOW_HOLD is set.
// The phase is kept as three counters (sub-bit, slot, half) so that no
// division is needed for MCLK_PER_BIT values that are not powers of two.
module audio_i2s_tx #(
  parameter int  SAMPLE_WIDTH   = 16,
  parameter int  BITS_PER_CHAN  = 32,
  parameter int  MCLK_PER_BIT   = 4,
  parameter int  FIFO_DEPTH     = 4,
  parameter int  UNDERFLOW_HOLD = 0,
  localparam int LEVEL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk_12_288_mhz,
  input  logic               reset,
  audio_i2s_tx_if.slave      s,
  input  logic               mute,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [15:0]        underflow_count,
  output logic               audio_mclk,
  output logic               audio_dac,
  output logic               audio_lrck
);

  localparam int SUB_W  = (MCLK_PER_BIT > 1) ? $clog2(MCLK_PER_BIT) : 1;
  localparam int SLOT_W = (BITS_PER_CHAN > 1) ? $clog2(BITS_PER_CHAN) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PAIR_W = 2 * SAMPLE_WIDTH;
  localparam bit HOLD   = (UNDERFLOW_HOLD != 0);

  // ------------------------------------------------------------------
  // Phase counters and serial output flops
  // ------------------------------------------------------------------
  logic [SUB_W-1:0]  r_sub;
  logic [SUB_W-1:0]  w_sub_next;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_next;
  logic              r_half;
  logic              w_half_next;
  logic              w_sub_last;
  logic              w_slot_last;
  logic              w_load;
  logic              r_sclk;
  logic              w_sclk_next;
  logic              w_dac_strobe;
  logic              r_lrck;
  logic              r_dac;
  logic              w_dac_next;

  // Frame being transmitted and last popped pair.
  logic [SAMPLE_WIDTH-1:0] r_frame_left;
  logic [SAMPLE_WIDTH-1:0] r_frame_right;
  logic [SAMPLE_WIDTH-1:0] r_last_left;
  logic [SAMPLE_WIDTH-1:0] r_last_right;
  logic [15:0]             r_underflow;

  // Per-slot bit maps of the current frame, one per channel.
  logic [BITS_PER_CHAN-1:0] w_left_slots;
  logic [BITS_PER_CHAN-1:0] w_right_slots;

  // ------------------------------------------------------------------
  // FIFO state
  // ------------------------------------------------------------------
  logic [PAIR_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_level_next;
  logic               r_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_nonempty;
  logic [PAIR_W-1:0]  w_head;
  logic [SAMPLE_WIDTH-1:0] w_head_left;
  logic [SAMPLE_WIDTH-1:0] w_head_right;

  // Step the phase by one clock; wrapping out of the right half is the
  // frame boundary, where the next pair is loaded.
  always_comb begin
    w_sub_last   = (r_sub == SUB_W'(MCLK_PER_BIT - 1));
    w_slot_last  = (r_slot == SLOT_W'(BITS_PER_CHAN - 1));
    w_sub_next   = w_sub_last ? '0 : r_sub + SUB_W'(1);
    w_slot_next  = r_slot;
    w_half_next  = r_half;
    if (w_sub_last) begin
      w_slot_next = w_slot_last ? '0 : r_slot + SLOT_W'(1);
      if (w_slot_last) begin
        w_half_next = ~r_half;
      end
    end
    w_load       = w_sub_last && w_slot_last && r_half;
    w_sclk_next  = (w_sub_next >= SUB_W'(MCLK_PER_BIT / 2));
    // Data moves only on a falling bit clock, i.e. when entering sub 0.
    w_dac_strobe = r_sclk && !w_sclk_next;
  end

  // Slot 0 is the one-bit I2S delay, slots 1..SAMPLE_WIDTH carry MSB..LSB,
  // the rest of the half-frame pads with zero.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CHAN; gi++) begin : g_slot
      if (gi >= 1 && gi <= SAMPLE_WIDTH) begin : g_data
        assign w_left_slots[gi]  = r_frame_left[SAMPLE_WIDTH-gi];
        assign w_right_slots[gi] = r_frame_right[SAMPLE_WIDTH-gi];
      end else begin : g_pad
        assign w_left_slots[gi]  = 1'b0;
        assign w_right_slots[gi] = 1'b0;
      end
    end
  endgenerate

  // Choose the data bit for the slot being entered.
  always_comb begin
    w_dac_next = 1'b0;
    if (w_half_next) begin
      w_dac_next = w_right_slots[w_slot_next];
    end else begin
      w_dac_next = w_left_slots[w_slot_next];
    end
  end

  // Phase register: reset parks it on the last clock of a frame so the
  // first clock after release enters phase 0 and performs a load.
  always_ff @(posedge clk_12_288_mhz) begin
    if (reset) begin
      r_sub  <= SUB_W'(MCLK_PER_BIT - 1);
      r_slot <= SLOT_W'(BITS_PER_CHAN - 1);
      r_half <= 1'b1;
      r_sclk <= 1'b0;
      r_lrck <= 1'b0;
      r_dac  <= 1'b0;
    end else begin
      r_sub  <= w_sub_next;
      r_slot <= w_slot_next;
      r_half <= w_half_next;
      r_sclk <= w_sclk_next;
      r_lrck <= w_half_next;
      if (w_dac_strobe) begin
        r_dac <= w_dac_next;
      end
    end
  end

  // ------------------------------------------------------------------
  // Sample FIFO
  // ------------------------------------------------------------------
  // The pop decision looks only at the registered level, so a pair pushed
  // on the load edge is stored but never bypasses into that frame.
  always_comb begin
    w_fifo_nonempty = (r_level != '0);
    w_push          = s.s_valid && r_ready && !reset;
    w_pop           = w_load && w_fifo_nonempty;
    w_head          = r_mem[r_rd_ptr];
    w_head_left     = w_head[PAIR_W-1 -: SAMPLE_WIDTH];
    w_head_right    = w_head[SAMPLE_WIDTH-1:0];
    w_level_next    = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LEVEL_W'(1);
      2'b01:   w_level_next = r_level - LEVEL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  // Pointers, level and ready; ready is registered so the stream sees no
  // combinational path from the frame-boundary pop.
  always_ff @(posedge clk_12_288_mhz) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= w_level_next;
      r_ready <= (w_level_next != LEVEL_W'(FIFO_DEPTH));
    end
  end

  // Storage array; contents need no reset because the pointers do.
  always_ff @(posedge clk_12_288_mhz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s.s_left, s.s_right};
    end
  end

  // ------------------------------------------------------------------
  // Frame load
  // ------------------------------------------------------------------
  // At each boundary pop into the frame (muted frames still consume the
  // pair), or count an underflow and send silence / the held pair.
  always_ff @(posedge clk_12_288_mhz) begin
    if (reset) begin
      r_frame_left  <= '0;
      r_frame_right <= '0;
      r_last_left   <= '0;
      r_last_right  <= '0;
      r_underflow   <= '0;
    end else if (w_load) begin
      if (w_fifo_nonempty) begin
        r_last_left  <= w_head_left;
        r_last_right <= w_head_right;
        if (mute) begin
          r_frame_left  <= '0;
          r_frame_right <= '0;
        end else begin
          r_frame_left  <= w_head_left;
          r_frame_right <= w_head_right;
        end
      end else begin
        if (r_underflow != 16'hFFFF) begin
          r_underflow <= r_underflow + 16'd1;
        end
        if (mute || !HOLD) begin
          r_frame_left  <= '0;
          r_frame_right <= '0;
        end else begin
          r_frame_left  <= r_last_left;
          r_frame_right <= r_last_right;
        end
      end
    end
  end

  assign s.s_ready       = r_ready;
  assign fifo_level      = r_level;
  assign underflow_count = r_underflow;
  assign audio_mclk      = clk_12_288_mhz;
  assign audio_dac       = r_dac;
  assign audio_lrck      = r_lrck;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: two instances (silence and hold underflow policy)
// share one stimulus. A queue-based model of the frame rules predicts
// every output each clock; a vector table and short hand-written
// sequences cover the documented scenarios.
module tb_audio_i2s_tx;
  localparam int FRAME = 256;
  localparam int MPB   = 4;
  localparam int HALF  = 128;
  localparam int DEPTH = 4;
  localparam int NVEC  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        tb_reset;
  logic        tb_valid;
  logic        tb_mute;
  logic [15:0] tb_left;
  logic [15:0] tb_right;

  audio_i2s_tx_if #(.SAMPLE_WIDTH(16)) if0 ();
  audio_i2s_tx_if #(.SAMPLE_WIDTH(16)) if1 ();
  assign if0.s_valid = tb_valid;
  assign if0.s_left  = tb_left;
  assign if0.s_right = tb_right;
  assign if1.s_valid = tb_valid;
  assign if1.s_left  = tb_left;
  assign if1.s_right = tb_right;

  logic [2:0]  lvl0, lvl1;
  logic [15:0] ucnt0, ucnt1;
  logic        mclk0, mclk1, dac0, dac1, lrck0, lrck1;

  audio_i2s_tx #(.UNDERFLOW_HOLD(0)) dut0 (
    .clk_12_288_mhz(clk), .reset(tb_reset), .s(if0), .mute(tb_mute),
    .fifo_level(lvl0), .underflow_count(ucnt0), .audio_mclk(mclk0),
    .audio_dac(dac0), .audio_lrck(lrck0)
  );

  audio_i2s_tx #(.UNDERFLOW_HOLD(1)) dut1 (
    .clk_12_288_mhz(clk), .reset(tb_reset), .s(if1), .mute(tb_mute),
    .fifo_level(lvl1), .underflow_count(ucnt1), .audio_mclk(mclk1),
    .audio_dac(dac1), .audio_lrck(lrck1)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  int          m_ph;
  logic [31:0] m_frame0, m_frame1, m_last;
  int          m_ucnt;
  logic        m_ready;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected serial bit in phase ph of a frame holding {left,right}.
  function automatic logic exp_dac(input int ph, input logic [31:0] fr);
    int slot;
    logic [15:0] w;
    if (ph < 0) return 1'b0;
    slot = (ph / MPB) % 32;
    w = (ph >= HALF) ? fr[15:0] : fr[31:16];
    if (slot >= 1 && slot <= 16) return w[16 - slot];
    return 1'b0;
  endfunction

  // Apply the frame rules for one clock edge using the driven inputs.
  task automatic model_step();
    logic [31:0] p;
    logic        push;
    if (tb_reset) begin
      m_q.delete();
      m_ph     = -1;
      m_frame0 = '0;
      m_frame1 = '0;
      m_last   = '0;
      m_ucnt   = 0;
      m_ready  = 1'b0;
    end else begin
      push = tb_valid && m_ready;
      m_ph = (m_ph + 1) % FRAME;
      if (m_ph == 0) begin
        if (m_q.size() > 0) begin
          p = m_q.pop_front();
          m_last   = p;
          m_frame0 = tb_mute ? 32'h0 : p;
          m_frame1 = tb_mute ? 32'h0 : p;
        end else begin
          if (m_ucnt < 65535) m_ucnt++;
          m_frame0 = 32'h0;
          m_frame1 = tb_mute ? 32'h0 : m_last;
        end
      end
      if (push) m_q.push_back({tb_left, tb_right});
      m_ready = (m_q.size() != DEPTH);
    end
  endtask

  task automatic check_outputs();
    chk("lrck",        lrck0, m_ph >= HALF);
    chk("lrck_hold",   lrck1, m_ph >= HALF);
    chk("dac",         dac0, exp_dac(m_ph, m_frame0));
    chk("dac_hold",    dac1, exp_dac(m_ph, m_frame1));
    chk("ready",       if0.s_ready, m_ready);
    chk("ready_hold",  if1.s_ready, m_ready);
    chk("level",       lvl0, m_q.size());
    chk("level_hold",  lvl1, m_q.size());
    chk("ucount",      ucnt0, m_ucnt);
    chk("ucount_hold", ucnt1, m_ucnt);
    chk("mclk_lo",     {mclk0, mclk1}, 2'b00);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("mclk_hi", {mclk0, mclk1}, 2'b11);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_ph(input int target);
    int g;
    g = 0;
    do begin
      cycle();
      g++;
    end while (m_ph != target && g < FRAME + 4);
    chk($sformatf("wait_ph%0d", target), m_ph, target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        push;
    logic [15:0] l;
    logic [15:0] r;
    logic        mute;
    logic [63:0] exp_word;
    logic [63:0] exp_hold;
    int          exp_ucnt;
  } vec_t;
  vec_t tbl[NVEC];

  function automatic logic [63:0] fw(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
  endfunction

  logic [63:0] cap0, cap1;

  // One frame starting at ph 0; pushes vector nxt mid-frame, sets its mute
  // ahead of the next boundary, and captures both serial streams mid-slot.
  task automatic run_frame(input int nxt);
    cap0 = '0;
    cap1 = '0;
    for (int k = 0; k < FRAME; k++) begin
      cycle();
      tb_valid = 1'b0;
      if (nxt >= 0 && nxt < NVEC && m_ph == 40 && tbl[nxt].push) begin
        tb_valid = 1'b1;
        tb_left  = tbl[nxt].l;
        tb_right = tbl[nxt].r;
      end
      if (m_ph == 200) tb_mute = (nxt >= 0 && nxt < NVEC) ? tbl[nxt].mute : 1'b0;
      if (m_ph % MPB == MPB / 2) begin
        cap0 = {cap0[62:0], dac0};
        cap1 = {cap1[62:0], dac1};
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pct;
    int u_ref;
    tbl[0] = '{1'b1, 16'hA5A5, 16'h0F0F, 1'b0, fw(16'hA5A5, 16'h0F0F), fw(16'hA5A5, 16'h0F0F), 1};
    tbl[1] = '{1'b1, 16'h8001, 16'h7FFE, 1'b0, fw(16'h8001, 16'h7FFE), fw(16'h8001, 16'h7FFE), 1};
    tbl[2] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 64'h0, fw(16'h8001, 16'h7FFE), 2};
    tbl[3] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 64'h0, 64'h0, 2};
    tbl[4] = '{1'b1, 16'h1234, 16'hFEDC, 1'b0, fw(16'h1234, 16'hFEDC), fw(16'h1234, 16'hFEDC), 2};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 64'h0, 64'h0, 3};
    tbl[6] = '{1'b1, 16'h0001, 16'h8000, 1'b0, fw(16'h0001, 16'h8000), fw(16'h0001, 16'h8000), 3};
    tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 64'h0, fw(16'h0001, 16'h8000), 4};

    tb_reset = 1'b1;
    tb_valid = 1'b0;
    tb_mute  = 1'b0;
    tb_left  = '0;
    tb_right = '0;
    repeat (3) cycle();
    chk("reset_ready", if0.s_ready, 1'b0);
    tb_reset = 1'b0;

    // First frame after release underflows; vector 0 is queued during it.
    run_frame(0);
    for (int i = 0; i < NVEC; i++) begin
      run_frame(i + 1);
      $display("vec %0d: push=%0b L=%h R=%h mute=%0b word=%h hold=%h ucount=%0d",
               i, tbl[i].push, tbl[i].l, tbl[i].r, tbl[i].mute, cap0, cap1, ucnt0);
      chk($sformatf("vec%0d_word", i), cap0, tbl[i].exp_word);
      chk($sformatf("vec%0d_hold", i), cap1, tbl[i].exp_hold);
      chk($sformatf("vec%0d_ucount", i), ucnt0, tbl[i].exp_ucnt);
    end

    // Fill the FIFO between boundaries, then watch the boundary pop.
    wait_ph(10);
    tb_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tb_left  = 16'($urandom);
      tb_right = 16'($urandom);
      cycle();
    end
    chk("fill_level", lvl0, 3'd4);
    chk("fill_ready", if0.s_ready, 1'b0);
    wait_ph(0);
    chk("pop_level", lvl0, 3'd3);
    chk("pop_ready", if0.s_ready, 1'b1);
    tb_valid = 1'b0;
    $display("fill: level 4 then 3 after boundary");

    // Muted frames still drain the FIFO and never count underflow.
    u_ref   = m_ucnt;
    tb_mute = 1'b1;
    wait_ph(0);
    chk("mute_level_a", lvl0, 3'd2);
    wait_ph(0);
    chk("mute_level_b", lvl0, 3'd1);
    wait_ph(0);
    chk("mute_level_c", lvl0, 3'd0);
    chk("mute_ucount", ucnt0, u_ref);
    tb_mute = 1'b0;
    $display("mute: drained 3 entries, ucount=%0d", ucnt0);

    // Reset mid-frame with entries queued.
    tb_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tb_left  = 16'(16'h1111 * (k + 1));
      tb_right = 16'(16'h2222 * (k + 1));
      cycle();
    end
    tb_valid = 1'b0;
    wait_ph(100);
    chk("pre_reset_level", lvl0, 3'd3);
    tb_reset = 1'b1;
    cycle();
    chk("rst_dac", dac0, 1'b0);
    chk("rst_lrck", lrck0, 1'b0);
    chk("rst_level", lvl0, 3'd0);
    cycle();
    tb_reset = 1'b0;
    cycle();
    chk("rel_lrck", lrck0, 1'b0);
    chk("rel_ucount", ucnt0, 16'd1);
    chk("rel_level", lvl0, 3'd0);
    $display("reset at ph 100: fifo cleared, first frame underflowed");

    // Randomized traffic with varying fill rate, mute and one reset pulse.
    for (int f = 0; f < 14; f++) begin
      case (f % 5)
        0: pct = 0;
        1: pct = 20;
        2: pct = 100;
        3: pct = 3;
        default: pct = 50;
      endcase
      for (int k = 0; k < FRAME; k++) begin
        tb_valid = ($urandom_range(0, 99) < pct);
        tb_left  = 16'($urandom);
        tb_right = 16'($urandom);
        if (m_ph == 128) tb_mute = ($urandom_range(0, 4) == 0);
        tb_reset = (f == 8 && k >= 77 && k < 80);
        cycle();
      end
      $display("random frame %0d: rate=%0d level=%0d ucount=%0d", f, pct, lvl0, ucnt0);
    end
    tb_valid = 1'b0;
    tb_reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
